// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types for the arbiter and its requesters.
// Request/response bundles and the arbiter FSM state encoding.
package dbus_arbiter_pkg;

   typedef enum logic [1:0] {
      MSIZE1,
      MSIZE2,
      MSIZE4,
      MSIZE8
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic {
      IDLE,
      BUSY
   } arb_state_t;

endpackage

// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: memory stage (port 0) and a secondary
// requester (port 1) share one downstream bus, one transaction at a time.
module dbus_arbiter
   import dbus_arbiter_pkg::*;
#(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq0,
   output dbus_resp_t dresp0,
   input  dbus_req_t  dreq1,
   output dbus_resp_t dresp1,
   output dbus_req_t  dreq,
   input  dbus_resp_t dresp,
   output logic       busy
);

   arb_state_t state;
   arb_state_t nextState;
   logic       grantIdx;
   logic       ptr;
   dbus_req_t  reqLatch;
   logic       selIdx;
   logic       anyValid;
   logic       accept;
   logic       finish;

   assign anyValid = dreq0.valid | dreq1.valid;
   assign accept   = (state == IDLE) & anyValid;
   assign finish   = (state == BUSY) & dresp.data_ok;
   assign busy     = (state == BUSY);

   // Pick the winning port; the pointer only matters on a tie.
   always_comb begin
      selIdx = 1'b0;
      unique case (1'b1)
         (dreq0.valid & dreq1.valid):
            selIdx = RR_ENABLE ? ptr : 1'b0;
         (!dreq0.valid & dreq1.valid):
            selIdx = 1'b1;
         default:
            selIdx = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Grant index, tie-break pointer and the frozen request copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         grantIdx <= 1'b0;
         ptr      <= 1'b0;
         reqLatch <= '0;
      end else begin
         if (accept) begin
            grantIdx <= selIdx;
            reqLatch <= selIdx ? dreq1 : dreq0;
         end
         if (finish) begin
            ptr <= ~grantIdx;
         end
      end
   end

   // Next state, downstream request and response steering.
   always_comb begin
      nextState = state;
      dreq      = '0;
      dresp0    = '0;
      dresp1    = '0;
      unique case (state)
         IDLE: begin
            if (anyValid) begin
               nextState = BUSY;
            end
         end
         BUSY: begin
            dreq       = reqLatch;
            dreq.valid = 1'b1;
            if (grantIdx) begin
               dresp1.addr_ok = dresp.addr_ok;
               dresp1.data_ok = dresp.data_ok;
               dresp1.data    = dresp.data_ok ? dresp.data : '0;
            end else begin
               dresp0.addr_ok = dresp.addr_ok;
               dresp0.data_ok = dresp.data_ok;
               dresp0.data    = dresp.data_ok ? dresp.data : '0;
            end
            if (dresp.data_ok) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter: RR_ENABLE, default 1, 1 = round-robin between ports, 0 = fixed priority with port 0 highest.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: dreq0  input  dbus_req_t  port 0 request (memory stage).
REQ-005 SHALL have port: dresp0  output  dbus_resp_t  port 0 response.
REQ-006 SHALL have port: dreq1  input  dbus_req_t  port 1 request (secondary requester, e.g. page walker).
REQ-007 SHALL have port: dresp1  output  dbus_resp_t  port 1 response.
REQ-008 SHALL have port: dreq  output  dbus_req_t  downstream request to the data bus.
REQ-009 SHALL have port: dresp  input  dbus_resp_t  downstream response.
REQ-010 SHALL have port: busy  output  1  high while state is BUSY.

Function
REQ-011 SHALL use an FSM with two states: IDLE and BUSY.
REQ-012 SHALL, in IDLE, hold downstream dreq.valid at 0.
REQ-013 SHALL, in IDLE, do nothing on a cycle with no upstream valid.
REQ-014 SHALL, in IDLE with at least one upstream valid, select exactly one port, latch its full dbus_req_t (valid, addr, size, strobe, data) and its index, and go to BUSY the next cycle.
REQ-015 SHALL arbitrate as follows: one port valid -> that port wins; both valid -> pointer port wins when RR_ENABLE=1, port 0 wins when RR_ENABLE=0.
REQ-016 SHALL, in BUSY, drive dreq from the latched copy with valid=1, unchanged for the whole transaction, regardless of upstream changes.
REQ-017 SHALL, in BUSY on the cycle dresp.data_ok=1: pass dresp.data and data_ok=1 combinationally to the granted port, return to IDLE next cycle, and set the pointer to the non-granted port.
REQ-018 SHALL pass dresp.addr_ok combinationally to the granted port only while BUSY.
REQ-019 SHALL drive the non-granted port, and both ports in IDLE, with addr_ok=0, data_ok=0, data=0.
REQ-020 SHALL have latency: upstream valid in cycle N (IDLE) -> dreq.valid=1 in cycle N+1; earliest data_ok to the requester in cycle N+1; one IDLE cycle between back-to-back transactions.
REQ-021 SHALL complete a transaction whose requester drops valid mid-transaction, still pulse data_ok, and not cancel it.
REQ-022 SHALL ignore a new request that arrives while BUSY until IDLE; the requester holds valid until its data_ok.
REQ-023 SHALL ignore dresp.data_ok when it arrives in IDLE.
REQ-024 SHALL have no state other than the FSM state, the grant index, the priority pointer and the latched request.

Reset
REQ-025 SHALL, on reset (including mid-transaction): go to state IDLE; drive dreq.valid=0 and all latched request fields to 0; clear the grant index to 0; set the pointer to port 0; drive busy=0 and all dresp0/dresp1 fields to 0 from the next cycle.
REQ-026 SHALL give no response to the aborted requester after reset; a data_ok from the bus in the cycle after reset SHALL be ignored.

Structure
REQ-027 SHALL take dbus_req_t and dbus_resp_t from the shared common package.
REQ-028 SHALL declare the FSM state enum (IDLE, BUSY) as arb_state_t in the shared common package.
REQ-029 SHALL be a single module with no sub-modules; the two-input select is inline combinational logic.

Verification
REQ-030 SHALL cover single request: dreq0 valid addr=0x80000010, size MSIZE8, strobe=0, held; bus data_ok on the 3rd BUSY cycle with data=0xDEADBEEF -> dreq.valid rises the cycle after the request, dresp0.data_ok=1 with data 0xDEADBEEF in that same cycle, dresp1 all zero.
REQ-031 SHALL cover a simultaneous request, RR_ENABLE=1, after reset: both valid in the same cycle -> port 0 served first, port 1 served next (after one IDLE cycle), then port 0 again if both still valid.
REQ-032 SHALL cover fixed priority, RR_ENABLE=0: both ports continuously valid -> port 0 served every transaction, port 1 never served.
REQ-033 SHALL cover request stability: port 1 write (strobe=0xFF, data=0x1122334455667788) granted, then port 1 changes addr/data mid-transaction -> dreq fields stay at the latched values until data_ok.
REQ-034 SHALL cover reset mid-operation: reset asserted on the 2nd BUSY cycle -> next cycle dreq.valid=0, busy=0; a bus data_ok next cycle produces no data_ok on either port.
REQ-035 SHALL cover a requester dropping valid: dreq0 drops valid after grant -> transaction completes and dresp0.data_ok pulses once.
